// File: rtl/riscv_test_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : riscv_test_sequencer
//  Purpose  : Run controller for riscv_wrapper. It holds the core in reset,
//             runs an optional BIST phase (TEST_SEQ_BIST_EN), then a software
//             run under watchdog limits, and latches a single verdict.
//  Revision : 1.0 - initial release
// ============================================================================
module riscv_test_sequencer #(
    parameter int unsigned BIST_START_TIMEOUT = 16,
    parameter int unsigned BIST_RUN_TIMEOUT   = 65536,
    parameter int unsigned SW_TIMEOUT         = 1000000,
    parameter int unsigned CORE_RST_CYCLES    = 8
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        go_i,
    input  logic        abort_i,
    input  logic        test_i,
    input  logic        go_nogo_i,
    input  logic        tests_passed_i,
    input  logic        tests_failed_i,
    input  logic        exit_valid_i,
    input  logic [31:0] exit_value_i,
    output logic        core_rst_no,
    output logic        start_test_o,
    output logic        fetch_enable_o,
    output logic        busy_o,
    output logic        done_o,
    output logic        pass_o,
    output logic [2:0]  status_o,
    output logic [31:0] exit_value_o,
    output logic [31:0] run_cycles_o
);

    localparam logic [2:0] c_S_IDLE     = 3'd0;
    localparam logic [2:0] c_S_CRST     = 3'd1;
    localparam logic [2:0] c_S_BIST_REQ = 3'd2;
    localparam logic [2:0] c_S_BIST_RUN = 3'd3;
    localparam logic [2:0] c_S_SW_RUN   = 3'd4;
    localparam logic [2:0] c_S_DONE     = 3'd5;

    localparam logic [2:0] c_ST_NONE    = 3'd0;
    localparam logic [2:0] c_ST_PASS    = 3'd1;
    localparam logic [2:0] c_ST_SW_FAIL = 3'd2;
    localparam logic [2:0] c_ST_SW_TO   = 3'd5;
    localparam logic [2:0] c_ST_ABORT   = 3'd6;

`ifdef TEST_SEQ_BIST_EN
    localparam logic [2:0] c_ST_BIST_FAIL = 3'd3;
    localparam logic [2:0] c_ST_BIST_TO   = 3'd4;
    localparam logic [2:0] c_S_AFTER_CRST = c_S_BIST_REQ;
`else
    localparam logic [2:0] c_S_AFTER_CRST = c_S_SW_RUN;
`endif

    // Counter preload is (limit - 1) so that zero is reached on the Nth cycle
    function automatic logic [31:0] f_load(input logic [2:0] st);
        case (st)
            c_S_CRST:     f_load = 32'(CORE_RST_CYCLES - 1);
            c_S_BIST_REQ: f_load = 32'(BIST_START_TIMEOUT - 1);
            c_S_BIST_RUN: f_load = 32'(BIST_RUN_TIMEOUT - 1);
            c_S_SW_RUN:   f_load = 32'(SW_TIMEOUT - 1);
            default:      f_load = 32'd0;
        endcase
    endfunction

    logic [2:0]  r_state;
    logic [31:0] r_cnt;
    logic        r_core_rst_n;
    logic        r_fetch_en;
    logic        r_busy;
    logic        r_done;
    logic        r_pass;
    logic [2:0]  r_status;
    logic [31:0] r_exit_value;
    logic [31:0] r_run_cycles;

    logic [2:0]  w_state_nxt;
    logic [31:0] w_cnt_nxt;
    logic        w_done_nxt;
    logic        w_pass_nxt;
    logic [2:0]  w_status_nxt;
    logic [31:0] w_exit_nxt;
    logic [31:0] w_cycles_nxt;
    logic        w_expired;

    assign w_expired = (r_cnt == 32'd0);

    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_done_nxt   = r_done;
        w_pass_nxt   = r_pass;
        w_status_nxt = r_status;
        w_exit_nxt   = r_exit_value;
        w_cycles_nxt = r_run_cycles;

        case (r_state)
            c_S_IDLE: begin
                if (go_i) begin
                    w_state_nxt  = c_S_CRST;
                    w_done_nxt   = 1'b0;
                    w_pass_nxt   = 1'b0;
                    w_status_nxt = c_ST_NONE;
                    w_exit_nxt   = 32'd0;
                    w_cycles_nxt = 32'd0;
                end
            end
            c_S_CRST: begin
                if (abort_i) begin
                    w_state_nxt  = c_S_DONE;
                    w_status_nxt = c_ST_ABORT;
                end else if (w_expired) begin
                    w_state_nxt = c_S_AFTER_CRST;
                end
            end
`ifdef TEST_SEQ_BIST_EN
            c_S_BIST_REQ: begin
                if (abort_i) begin
                    w_state_nxt  = c_S_DONE;
                    w_status_nxt = c_ST_ABORT;
                end else if (test_i) begin
                    w_state_nxt = c_S_BIST_RUN;
                end else if (w_expired) begin
                    w_state_nxt  = c_S_DONE;
                    w_status_nxt = c_ST_BIST_TO;
                end
            end
            c_S_BIST_RUN: begin
                if (abort_i) begin
                    w_state_nxt  = c_S_DONE;
                    w_status_nxt = c_ST_ABORT;
                end else if (!test_i) begin
                    if (go_nogo_i) begin
                        w_state_nxt = c_S_SW_RUN;
                    end else begin
                        w_state_nxt  = c_S_DONE;
                        w_status_nxt = c_ST_BIST_FAIL;
                    end
                end else if (w_expired) begin
                    w_state_nxt  = c_S_DONE;
                    w_status_nxt = c_ST_BIST_TO;
                end
            end
`endif
            c_S_SW_RUN: begin
                if (r_run_cycles != 32'hFFFF_FFFF) begin
                    w_cycles_nxt = r_run_cycles + 32'd1;
                end
                // Exit code is captured even when a tests_* flag wins the verdict
                if (exit_valid_i && !abort_i) begin
                    w_exit_nxt = exit_value_i;
                end
                if (abort_i) begin
                    w_state_nxt  = c_S_DONE;
                    w_status_nxt = c_ST_ABORT;
                end else if (tests_failed_i) begin
                    w_state_nxt  = c_S_DONE;
                    w_status_nxt = c_ST_SW_FAIL;
                end else if (tests_passed_i) begin
                    w_state_nxt  = c_S_DONE;
                    w_status_nxt = c_ST_PASS;
                end else if (exit_valid_i) begin
                    w_state_nxt  = c_S_DONE;
                    w_status_nxt = (exit_value_i == 32'd0) ? c_ST_PASS : c_ST_SW_FAIL;
                end else if (w_expired) begin
                    w_state_nxt  = c_S_DONE;
                    w_status_nxt = c_ST_SW_TO;
                end
            end
            c_S_DONE: begin
                if (!go_i) begin
                    w_state_nxt = c_S_IDLE;
                end
            end
            default: begin
                w_state_nxt = c_S_IDLE;
            end
        endcase

        if (w_state_nxt == c_S_DONE && r_state != c_S_DONE) begin
            w_done_nxt = 1'b1;
            w_pass_nxt = (w_status_nxt == c_ST_PASS);
        end

        if (w_state_nxt != r_state) begin
            w_cnt_nxt = f_load(w_state_nxt);
        end else if (!w_expired) begin
            w_cnt_nxt = r_cnt - 32'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state      <= c_S_IDLE;
            r_cnt        <= 32'd0;
            r_core_rst_n <= 1'b1;
            r_fetch_en   <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_pass       <= 1'b0;
            r_status     <= c_ST_NONE;
            r_exit_value <= 32'd0;
            r_run_cycles <= 32'd0;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_core_rst_n <= (w_state_nxt != c_S_CRST);
            r_fetch_en   <= (w_state_nxt == c_S_SW_RUN);
            r_busy       <= (w_state_nxt == c_S_CRST) || (w_state_nxt == c_S_BIST_REQ) ||
                            (w_state_nxt == c_S_BIST_RUN) || (w_state_nxt == c_S_SW_RUN);
            r_done       <= w_done_nxt;
            r_pass       <= w_pass_nxt;
            r_status     <= w_status_nxt;
            r_exit_value <= w_exit_nxt;
            r_run_cycles <= w_cycles_nxt;
        end
    end

`ifdef TEST_SEQ_BIST_EN
    logic r_start_test;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_start_test <= 1'b0;
        end else begin
            r_start_test <= (w_state_nxt == c_S_BIST_REQ);
        end
    end

    assign start_test_o = r_start_test;
`else
    logic w_unused_bist;
    assign w_unused_bist = test_i ^ go_nogo_i;
    assign start_test_o  = 1'b0;
`endif

    assign core_rst_no    = r_core_rst_n;
    assign fetch_enable_o = r_fetch_en;
    assign busy_o         = r_busy;
    assign done_o         = r_done;
    assign pass_o         = r_pass;
    assign status_o       = r_status;
    assign exit_value_o   = r_exit_value;
    assign run_cycles_o   = r_run_cycles;

endmodule
`default_nettype wire

// File: tb/tb_riscv_test_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_riscv_test_sequencer
//  Purpose  : Directed bench for riscv_test_sequencer with a phase-level
//             reference model compared every cycle, plus literal verdict checks.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_riscv_test_sequencer;

    localparam int unsigned C_BST = 16;
    localparam int unsigned C_BRT = 64;
    localparam int unsigned C_SW  = 120;
    localparam int unsigned C_RST = 8;
`ifdef TEST_SEQ_BIST_EN
    localparam bit C_BIST = 1'b1;
`else
    localparam bit C_BIST = 1'b0;
`endif

    localparam int P_IDLE = 0, P_CRST = 1, P_REQ = 2, P_RUN = 3, P_SW = 4, P_DONE = 5;

    logic        clk = 1'b0, rst = 1'b1;
    logic        go = 1'b0, abort = 1'b0, test = 1'b0, go_nogo = 1'b0;
    logic        t_pass = 1'b0, t_fail = 1'b0, ex_valid = 1'b0;
    logic [31:0] ex_value = 32'd0;

    logic        core_rst_no, start_test_o, fetch_enable_o, busy_o, done_o, pass_o;
    logic [2:0]  status_o;
    logic [31:0] exit_value_o, run_cycles_o;

    int n_cmp = 0, n_err = 0;
    bit seen_fetch = 1'b0;

    riscv_test_sequencer #(
        .BIST_START_TIMEOUT (C_BST),
        .BIST_RUN_TIMEOUT   (C_BRT),
        .SW_TIMEOUT         (C_SW),
        .CORE_RST_CYCLES    (C_RST)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .go_i           (go),
        .abort_i        (abort),
        .test_i         (test),
        .go_nogo_i      (go_nogo),
        .tests_passed_i (t_pass),
        .tests_failed_i (t_fail),
        .exit_valid_i   (ex_valid),
        .exit_value_i   (ex_value),
        .core_rst_no    (core_rst_no),
        .start_test_o   (start_test_o),
        .fetch_enable_o (fetch_enable_o),
        .busy_o         (busy_o),
        .done_o         (done_o),
        .pass_o         (pass_o),
        .status_o       (status_o),
        .exit_value_o   (exit_value_o),
        .run_cycles_o   (run_cycles_o)
    );

    always #5 clk = ~clk;

    // Reference model: phase + elapsed cycles in phase, verdict per the rules
    int          m_phase = P_IDLE;
    int unsigned m_age = 0;
    bit          m_valid = 1'b0;
    bit          m_done = 1'b0, m_pass = 1'b0;
    int          m_status = 0;
    logic [31:0] m_exit = 32'd0, m_cycles = 32'd0;

    always @(posedge clk) begin : model
        int nxt;
        int st;
        bit term;
        if (rst) begin
            m_phase = P_IDLE; m_age = 0; m_done = 1'b0; m_pass = 1'b0;
            m_status = 0; m_exit = 32'd0; m_cycles = 32'd0; m_valid = 1'b1;
        end else begin
            nxt = m_phase; st = 0; term = 1'b0;
            case (m_phase)
                P_IDLE: if (go) begin
                    nxt = P_CRST; m_done = 1'b0; m_pass = 1'b0;
                    m_status = 0; m_exit = 32'd0; m_cycles = 32'd0;
                end
                P_CRST: begin
                    if (abort) begin term = 1'b1; st = 6; end
                    else if (m_age + 1 == C_RST) nxt = C_BIST ? P_REQ : P_SW;
                end
                P_REQ: begin
                    if (abort) begin term = 1'b1; st = 6; end
                    else if (test) nxt = P_RUN;
                    else if (m_age + 1 == C_BST) begin term = 1'b1; st = 4; end
                end
                P_RUN: begin
                    if (abort) begin term = 1'b1; st = 6; end
                    else if (!test) begin
                        if (go_nogo) nxt = P_SW;
                        else begin term = 1'b1; st = 3; end
                    end else if (m_age + 1 == C_BRT) begin term = 1'b1; st = 4; end
                end
                P_SW: begin
                    if (m_cycles != 32'hFFFF_FFFF) m_cycles = m_cycles + 1;
                    if (abort) begin term = 1'b1; st = 6; end
                    else begin
                        if (ex_valid) m_exit = ex_value;
                        if (t_fail) begin term = 1'b1; st = 2; end
                        else if (t_pass) begin term = 1'b1; st = 1; end
                        else if (ex_valid) begin term = 1'b1; st = (ex_value == 0) ? 1 : 2; end
                        else if (m_age + 1 == C_SW) begin term = 1'b1; st = 5; end
                    end
                end
                default: if (!go) nxt = P_IDLE;
            endcase
            if (term) begin
                nxt = P_DONE; m_status = st; m_done = 1'b1; m_pass = (st == 1);
            end
            if (nxt != m_phase) begin m_phase = nxt; m_age = 0; end
            else m_age = m_age + 1;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (fetch_enable_o === 1'b1) seen_fetch = 1'b1;
        if (m_valid) begin
            chk("core_rst_no",    core_rst_no,    32'(m_phase != P_CRST));
            chk("start_test_o",   start_test_o,   32'(m_phase == P_REQ));
            chk("fetch_enable_o", fetch_enable_o, 32'(m_phase == P_SW));
            chk("busy_o",         busy_o,         32'(m_phase >= P_CRST && m_phase <= P_SW));
            chk("done_o",         done_o,         32'(m_done));
            chk("pass_o",         pass_o,         32'(m_pass));
            chk("status_o",       status_o,       32'(m_status));
            chk("exit_value_o",   exit_value_o,   m_exit);
            chk("run_cycles_o",   run_cycles_o,   m_cycles);
        end
    end

    function automatic bit sig_of(input int which);
        case (which)
            0:       return fetch_enable_o === 1'b1;
            1:       return start_test_o === 1'b1;
            default: return done_o === 1'b1;
        endcase
    endfunction

    task automatic wait_on(input int which, input string nm, input int budget);
        int n;
        n = 0;
        while (!sig_of(which) && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (!sig_of(which)) begin
            n_cmp++;
            n_err++;
            $display("FAIL wait_%s: still 0 after %0d cycles, required 1", nm, budget);
        end
    endtask

    // Brings a run to SW cycle 1, passing BIST with go when it is built in
    task automatic start_run();
        go = 1'b1;
`ifdef TEST_SEQ_BIST_EN
        wait_on(1, "start_test", 40);
        test = 1'b1;
        repeat (2) @(negedge clk);
        test = 1'b0; go_nogo = 1'b1;
        @(negedge clk);
        go_nogo = 1'b0;
`endif
        wait_on(0, "fetch_enable", 40);
    endtask

    task automatic end_run();
        go = 1'b0;
        @(negedge clk);
    endtask

    task automatic check_verdict(input string nm, input int st, input logic [31:0] ex, input int cyc);
        chk({nm, ".done"},   done_o,       32'd1);
        chk({nm, ".status"}, status_o,     32'(st));
        chk({nm, ".pass"},   pass_o,       32'(st == 1));
        chk({nm, ".exit"},   exit_value_o, ex);
        chk({nm, ".cycles"}, run_cycles_o, 32'(cyc));
    endtask

    initial begin : stim
        int n;
        repeat (3) @(negedge clk);
        chk("reset.core_rst_no", core_rst_no, 32'd1);
        chk("reset.busy",        busy_o,      32'd0);
        chk("reset.fetch",       fetch_enable_o, 32'd0);
        chk("reset.done",        done_o,      32'd0);
        chk("reset.status",      status_o,    32'd0);
        chk("reset.cycles",      run_cycles_o, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Nominal pass, measuring the core reset pulse
        go = 1'b1;
        @(negedge clk);
        n = 0;
        while (core_rst_no === 1'b0 && n < 100) begin n++; @(negedge clk); end
        chk("crst_len", 32'(n), 32'd8);
`ifdef TEST_SEQ_BIST_EN
        repeat (2) @(negedge clk);
        test = 1'b1;
        @(negedge clk);
        repeat (4) @(negedge clk);
        test = 1'b0; go_nogo = 1'b1;
        @(negedge clk);
        go_nogo = 1'b0;
`endif
        wait_on(0, "fetch_enable", 10);
        repeat (99) @(negedge clk);
        t_pass = 1'b1;
        @(negedge clk);
        t_pass = 1'b0;
        check_verdict("nominal", 1, 32'd0, 100);
        end_run();
        chk("idle_hold.done",   done_o,   32'd1);
        chk("idle_hold.status", status_o, 32'd1);

        // Non-zero exit value
        start_run();
        repeat (9) @(negedge clk);
        ex_valid = 1'b1; ex_value = 32'h5;
        @(negedge clk);
        ex_valid = 1'b0;
        check_verdict("exit5", 2, 32'h5, 10);
        end_run();

        // Zero exit value
        start_run();
        repeat (4) @(negedge clk);
        ex_valid = 1'b1; ex_value = 32'h0;
        @(negedge clk);
        ex_valid = 1'b0;
        check_verdict("exit0", 1, 32'h0, 5);
        end_run();

        // passed + failed + exit together: fail wins, exit still latched
        start_run();
        repeat (2) @(negedge clk);
        t_pass = 1'b1; t_fail = 1'b1; ex_valid = 1'b1; ex_value = 32'hDEAD_0007;
        @(negedge clk);
        t_pass = 1'b0; t_fail = 1'b0; ex_valid = 1'b0;
        check_verdict("both", 2, 32'hDEAD_0007, 3);
        end_run();

        // Same cycle with abort: abort wins
        start_run();
        t_pass = 1'b1; t_fail = 1'b1; ex_valid = 1'b1; ex_value = 32'h9; abort = 1'b1;
        @(negedge clk);
        t_pass = 1'b0; t_fail = 1'b0; ex_valid = 1'b0; abort = 1'b0;
        chk("abort_sw.status", status_o, 32'd6);
        chk("abort_sw.pass",   pass_o,   32'd0);
        chk("abort_sw.cycles", run_cycles_o, 32'd1);
        end_run();

        // Abort during core reset
        seen_fetch = 1'b0;
        go = 1'b1;
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_crst.status", status_o,    32'd6);
        chk("abort_crst.rst_n",  core_rst_no, 32'd1);
        chk("abort_crst.busy",   busy_o,      32'd0);
        chk("abort_crst.fetch_seen", 32'(seen_fetch), 32'd0);
        end_run();

        // Software watchdog, go held high, then toggle restart
        start_run();
        wait_on(2, "done", 200);
        check_verdict("watchdog", 5, 32'd0, 120);
        repeat (20) @(negedge clk);
        chk("hold.busy",   busy_o,   32'd0);
        chk("hold.status", status_o, 32'd5);
        go = 1'b0;
        @(negedge clk);
        go = 1'b1;
        @(negedge clk);
        chk("restart.busy",   busy_o,       32'd1);
        chk("restart.rst_n",  core_rst_no,  32'd0);
        chk("restart.done",   done_o,       32'd0);
        chk("restart.status", status_o,     32'd0);
        chk("restart.cycles", run_cycles_o, 32'd0);

        // Reset mid-sequence
        repeat (3) @(negedge clk);
        rst = 1'b1; go = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst.busy",   busy_o,      32'd0);
        chk("midrst.rst_n",  core_rst_no, 32'd1);
        chk("midrst.status", status_o,    32'd0);
        chk("midrst.done",   done_o,      32'd0);
        @(negedge clk);

`ifdef TEST_SEQ_BIST_EN
        // BIST no-go
        seen_fetch = 1'b0;
        go = 1'b1;
        wait_on(1, "start_test", 40);
        test = 1'b1;
        repeat (2) @(negedge clk);
        test = 1'b0; go_nogo = 1'b0;
        @(negedge clk);
        chk("nogo.status", status_o, 32'd3);
        chk("nogo.fetch_seen", 32'(seen_fetch), 32'd0);
        end_run();

        // BIST start timeout
        go = 1'b1;
        wait_on(1, "start_test", 40);
        n = 0;
        while (start_test_o === 1'b1 && n < 100) begin n++; @(negedge clk); end
        chk("bist_to.req_cycles", 32'(n), 32'd16);
        chk("bist_to.status", status_o, 32'd4);
        end_run();
`endif

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin : guard
        #200000;
        $display("FAIL global_timeout: simulation did not finish, required finish before %0t", $time);
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
